// File: rtl/rv32i_types.sv
// Shared RV32I memory-access types: funct3 encodings, access FSM states and
// request legality helpers used by the memory access unit.
package rv32i_types;

    typedef enum logic [2:0] {
        LD_LB  = 3'b000,
        LD_LH  = 3'b001,
        LD_LW  = 3'b010,
        LD_LBU = 3'b100,
        LD_LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mau_state_t;

    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        ok = 1'b0;
        if (is_store) begin
            case (f3)
                ST_SB, ST_SH, ST_SW: ok = 1'b1;
                default:             ok = 1'b0;
            endcase
        end else begin
            case (f3)
                LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: ok = 1'b1;
                default:                             ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Halfword codes need addr[0]=0, word codes need addr[1:0]=0.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            3'b001, 3'b101: bad = addr_lo[0];
            3'b010:         bad = (addr_lo != 2'b00);
            default:        bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store byte enables / lane-replicated write data
// and load byte/halfword extraction with sign or zero extension.
module mem_align
    import rv32i_types::*;
(
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_byte_enable,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_byte_enable = 4'b1111;
        o_wdata       = '0;
        if (i_is_store) begin
            case (i_funct3)
                ST_SB: begin
                    o_byte_enable = 4'b0001 << i_addr_lo;
                    o_wdata       = {4{i_store_data[7:0]}};
                end
                ST_SH: begin
                    o_byte_enable = 4'b0011 << i_addr_lo;
                    o_wdata       = {2{i_store_data[15:0]}};
                end
                default: begin
                    o_byte_enable = 4'b1111;
                    o_wdata       = i_store_data;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_load_data = i_rdata;
        case (i_funct3)
            LD_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            LD_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            LD_LBU:  o_load_data = {24'h000000, w_byte};
            LD_LHU:  o_load_data = {16'h0000, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access sequencer: validates a load/store, runs one bus
// access with a watchdog, and returns the extended load result.
//   state  | meaning
//   IDLE   | waiting for a legal request; illegal/misaligned ones pulse fault
//   ACCESS | strobe held from latched request until dmem_resp or watchdog expiry
//   DONE   | one-cycle completion (done, optional timeout), pipeline released
module mem_access_unit
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rs2_out,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        fault,
    output logic        timeout
);

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    mau_state_t  r_state;
    mau_state_t  w_state_nxt;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [31:0] r_load_data;
    logic [2:0]  r_funct3;
    logic        r_is_store;
    logic        r_timeout;
    logic [7:0]  r_count;

    logic        w_req;
    logic        w_bad;
    logic        w_accept;
    logic        w_tc;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld;

    assign w_req    = mem_req_valid && (mem_read ^ mem_write);
    assign w_bad    = !funct3_legal(funct3, mem_write) || addr_misaligned(funct3, MEM_alu_out[1:0]);
    assign w_accept = (r_state == S_IDLE) && w_req && !w_bad;
    assign w_tc     = (r_count == TC_LAST);

    mem_align u_align (
        .i_is_store    (r_is_store),
        .i_funct3      (r_funct3),
        .i_addr_lo     (r_addr[1:0]),
        .i_store_data  (r_store_data),
        .i_rdata       (dmem_rdata),
        .o_byte_enable (w_be),
        .o_wdata       (w_wdata),
        .o_load_data   (w_ld)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = '0;
        done             = 1'b0;
        stall            = 1'b0;
        fault            = 1'b0;
        timeout          = 1'b0;
        case (r_state)
            S_IDLE: begin
                fault = w_req && w_bad;
                stall = w_accept;
                if (w_accept) w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                dmem_read        = !r_is_store;
                dmem_write       = r_is_store;
                dmem_address     = {r_addr[31:2], 2'b00};
                dmem_wdata       = w_wdata;
                dmem_byte_enable = w_be;
                stall            = 1'b1;
                if (dmem_resp || w_tc) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                timeout     = r_timeout;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_store_data <= '0;
            r_load_data  <= '0;
            r_funct3     <= '0;
            r_is_store   <= 1'b0;
            r_timeout    <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr       <= MEM_alu_out;
                        r_store_data <= MEM_rs2_out;
                        r_funct3     <= funct3;
                        r_is_store   <= mem_write;
                        r_count      <= '0;
                        r_timeout    <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    // A response in the terminal-count cycle still completes normally.
                    if (dmem_resp) begin
                        if (!r_is_store) r_load_data <= w_ld;
                    end else if (w_tc) begin
                        r_load_data <= '0;
                        r_timeout   <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DONE:  r_timeout <= 1'b0;
                default: ;
            endcase
        end
    end

    assign load_data = r_load_data;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected bus
// and completion records; a monitor pops and compares as the DUT presents them.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] MEM_alu_out, MEM_rs2_out;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] load_data;
    logic        done, stall, fault, timeout;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .MEM_alu_out(MEM_alu_out), .MEM_rs2_out(MEM_rs2_out),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .load_data(load_data), .done(done), .stall(stall), .fault(fault), .timeout(timeout)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          ncyc;
    } bus_exp_t;

    typedef struct {
        logic        is_fault;
        logic        to;
        logic [31:0] ld;
    } cmp_exp_t;

    bus_exp_t bus_q[$];
    cmp_exp_t cmp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    string cur_test = "reset";
    logic [31:0] exp_ld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL [%s] %s: got 0x%08h, expected 0x%08h", cur_test, name, act, exp);
        end
    endtask

    task automatic exp_bus(input logic wr, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input int ncyc);
        bus_q.push_back('{wr: wr, addr: a, be: be, wdata: wd, ncyc: ncyc});
    endtask

    task automatic exp_cmp(input logic is_fault, input logic to, input logic [31:0] ld);
        cmp_q.push_back('{is_fault: is_fault, to: to, ld: ld});
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        bus_exp_t cur;
        cmp_exp_t ce;
        int run;
        run = 0;
        cur = '{wr: 1'b0, addr: 32'h0, be: 4'h0, wdata: 32'h0, ncyc: 0};
        forever begin
            @(negedge clk);
            if (dmem_read || dmem_write) begin
                if (run == 0) begin
                    if (bus_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL [%s] unexpected_bus: addr 0x%08h, none expected", cur_test, dmem_address);
                    end else begin
                        cur = bus_q.pop_front();
                        check("bus_dir", {31'h0, dmem_write}, {31'h0, cur.wr});
                        check("bus_addr", dmem_address, cur.addr);
                        check("bus_be", {28'h0, dmem_byte_enable}, {28'h0, cur.be});
                        if (cur.wr) check("bus_wdata", dmem_wdata, cur.wdata);
                    end
                end else begin
                    check("bus_hold_addr", dmem_address, cur.addr);
                    check("bus_hold_be", {28'h0, dmem_byte_enable}, {28'h0, cur.be});
                    if (cur.wr) check("bus_hold_wdata", dmem_wdata, cur.wdata);
                end
                run++;
            end else if (run > 0) begin
                check("strobe_cycles", run, cur.ncyc);
                run = 0;
            end
            if (done || fault) begin
                if (cmp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL [%s] unexpected_completion: done=%0b fault=%0b, none expected", cur_test, done, fault);
                end else begin
                    ce = cmp_q.pop_front();
                    check("completion_kind", {30'h0, fault, done}, ce.is_fault ? 32'd2 : 32'd1);
                    check("completion_stall", {31'h0, stall}, 32'h0);
                    if (ce.is_fault) begin
                        check("fault_no_strobe", {30'h0, dmem_read, dmem_write}, 32'h0);
                    end else begin
                        check("done_timeout", {31'h0, timeout}, {31'h0, ce.to});
                        check("done_load_data", load_data, ce.ld);
                    end
                end
            end else if (timeout) begin
                n_cmp++; n_err++;
                $display("FAIL [%s] timeout_without_done: got 1, expected 0", cur_test);
            end
        end
    end

    task automatic idle_inputs();
        mem_req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; MEM_alu_out = '0; MEM_rs2_out = '0;
        dmem_resp = 1'b0; dmem_rdata = '0;
    endtask

    // resp_at: ACCESS cycle (1-based) carrying dmem_resp; 0 means never respond.
    task automatic run(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input int resp_at,
                       input logic [31:0] rdat, input int exp_stalls, input logic exp_done);
        int stalls;
        logic saw_done;
        cur_test = name;
        stalls = 0;
        saw_done = 1'b0;
        @(posedge clk); #1;
        mem_req_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; MEM_alu_out = a; MEM_rs2_out = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (done) begin saw_done = 1'b1; break; end
            if (c == 0 && !stall) break;
            @(posedge clk); #1;
            mem_req_valid = 1'b0;
            dmem_resp  = (c + 1 == resp_at);
            dmem_rdata = (c + 1 == resp_at) ? rdat : 32'h0;
        end
        @(posedge clk); #1;
        idle_inputs();
        check("stall_cycles", stalls, exp_stalls);
        check("done_seen", {31'h0, saw_done}, {31'h0, exp_done});
    endtask

    initial begin : stimulus
        reset = 1'b1;
        idle_inputs();
        exp_ld = 32'h0;
        @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {26'h0, dmem_read, dmem_write, done, stall, fault, timeout}, 32'h0);
        check("reset_addr", dmem_address, 32'h0);
        check("reset_wdata", dmem_wdata, 32'h0);
        check("reset_be", {28'h0, dmem_byte_enable}, 32'h0);
        check("reset_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        exp_bus(1'b1, 32'h1000_0004, 4'b1111, 32'hDEAD_BEEF, 3);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("sw_basic", 1'b0, 1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 3, 32'h0, 4, 1'b1);

        exp_ld = 32'hFFFF_FF80;
        exp_bus(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 1);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("lb_sign", 1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 1, 32'h80FF_0000, 2, 1'b1);

        exp_ld = 32'h0000_0080;
        exp_bus(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 2);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("lbu_zero", 1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 2, 32'h80FF_0000, 3, 1'b1);

        exp_bus(1'b1, 32'h0000_2000, 4'b1100, 32'h1234_1234, 1);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("sh_upper", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_1234, 1, 32'h0, 2, 1'b1);

        exp_cmp(1'b1, 1'b0, 32'h0);
        run("lh_misaligned", 1'b1, 1'b0, 3'b001, 32'h0000_2001, 32'h0, 1, 32'h0, 0, 1'b0);

        exp_ld = 32'h0;
        exp_bus(1'b0, 32'h0000_3000, 4'b1111, 32'h0, 4);
        exp_cmp(1'b0, 1'b1, exp_ld);
        run("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 0, 32'h0, 5, 1'b1);

        exp_ld = 32'hFFFF_8001;
        exp_bus(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 2);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("lh_sign", 1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 2, 32'h8001_0000, 3, 1'b1);

        exp_bus(1'b1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 1);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("sb_lane1", 1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 1, 32'h0, 2, 1'b1);

        exp_ld = 32'h0000_ABCD;
        exp_bus(1'b0, 32'h0000_2000, 4'b1111, 32'h0, 1);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("lhu_lower", 1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'h0, 1, 32'h1234_ABCD, 2, 1'b1);

        exp_ld = 32'hCAFE_F00D;
        exp_bus(1'b0, 32'h0000_2004, 4'b1111, 32'h0, 4);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("lw_resp_at_limit", 1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'h0, 4, 32'hCAFE_F00D, 5, 1'b1);

        exp_cmp(1'b1, 1'b0, 32'h0);
        run("sw_misaligned", 1'b0, 1'b1, 3'b010, 32'h0000_2002, 32'h1, 1, 32'h0, 0, 1'b0);

        exp_cmp(1'b1, 1'b0, 32'h0);
        run("store_f3_100", 1'b0, 1'b1, 3'b100, 32'h0000_2000, 32'h1, 1, 32'h0, 0, 1'b0);

        exp_cmp(1'b1, 1'b0, 32'h0);
        run("load_f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_2000, 32'h0, 1, 32'h0, 0, 1'b0);

        run("read_and_write", 1'b1, 1'b1, 3'b010, 32'h0000_2000, 32'h0, 1, 32'h0, 0, 1'b0);
        run("neither_dir", 1'b0, 1'b0, 3'b010, 32'h0000_2000, 32'h0, 1, 32'h0, 0, 1'b0);

        // Reset lands in the second ACCESS cycle; the late response must be ignored.
        cur_test = "reset_abort";
        exp_bus(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 2);
        @(posedge clk); #1;
        mem_req_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; MEM_alu_out = 32'h0000_4000;
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("abort_ctrl", {26'h0, dmem_read, dmem_write, done, stall, fault, timeout}, 32'h0);
        check("abort_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_ctrl_later", {26'h0, dmem_read, dmem_write, done, stall}, 32'h0);
        check("abort_load_data_later", load_data, 32'h0);
        exp_ld = 32'h0;

        exp_ld = 32'h0BAD_F00D;
        exp_bus(1'b0, 32'h0000_5000, 4'b1111, 32'h0, 1);
        exp_cmp(1'b0, 1'b0, exp_ld);
        run("lw_after_abort", 1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 1, 32'h0BAD_F00D, 2, 1'b1);

        cur_test = "drain";
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bus_q_empty", bus_q.size(), 32'h0);
        check("cmp_q_empty", cmp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
